// File: rtl/fact_engine_if.sv
// Handshake and result bundle for fact_engine: start/n_in request in,
// result/done/busy/ovf status out.
interface fact_engine_if;
    logic        start;
    logic [4:0]  n_in;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        ovf;

    modport master (
        output start,
        output n_in,
        input  result,
        input  done,
        input  busy,
        input  ovf
    );

    modport slave (
        input  start,
        input  n_in,
        output result,
        output done,
        output busy,
        output ovf
    );
endinterface

// File: rtl/fact_engine.sv
// Sequential n! engine (n = 0..31) built on a 5-cycle shift-add multiply per factor.
// Optional macro FACT_OVF_SAT_EN saturates result to all-ones when ovf is set.
module fact_engine (
    input  logic         clk,
    input  logic         rst,
    fact_engine_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int PROD_W = DATA_W + 5;

`ifdef FACT_OVF_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CHECK, MUL, NEXT, DONE} state_t;

    state_t              state, state_nxt;
    logic [4:0]          n, n_nxt;
    logic [DATA_W-1:0]   acc, acc_nxt;
    logic [PROD_W-1:0]   prod, prod_nxt;
    logic [5:0]          k, k_nxt;
    logic [2:0]          i, i_nxt;
    logic [DATA_W-1:0]   result_q, result_nxt;
    logic                ovf_q, ovf_nxt;
    logic                done_q, done_nxt;
    logic                busy_q, busy_nxt;
    logic [PROD_W-1:0]   addend;

    function automatic logic [DATA_W-1:0] final_result(input logic [DATA_W-1:0] a,
                                                       input logic flag);
        return (SAT_EN && flag) ? {DATA_W{1'b1}} : a;
    endfunction

    // Partial product for the current multiplier bit of k
    assign addend = {{(PROD_W-DATA_W){1'b0}}, acc} << i;

    always_comb begin
        state_nxt  = state;
        n_nxt      = n;
        acc_nxt    = acc;
        prod_nxt   = prod;
        k_nxt      = k;
        i_nxt      = i;
        result_nxt = result_q;
        ovf_nxt    = ovf_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    n_nxt     = bus.n_in;
                    acc_nxt   = {{(DATA_W-1){1'b0}}, 1'b1};
                    k_nxt     = 6'd2;
                    ovf_nxt   = 1'b0;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (k > {1'b0, n}) begin
                    result_nxt = final_result(acc, ovf_q);
                    state_nxt  = DONE;
                end else begin
                    prod_nxt  = '0;
                    i_nxt     = 3'd0;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (k[i]) begin
                    prod_nxt = prod + addend;
                end
                i_nxt = i + 3'd1;
                if (i == 3'd4) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                acc_nxt   = prod[DATA_W-1:0];
                ovf_nxt   = ovf_q | (|prod[PROD_W-1:DATA_W]);
                k_nxt     = k + 6'd1;
                state_nxt = CHECK;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they align with it
        done_nxt = (state_nxt == DONE);
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            n        <= '0;
            acc      <= '0;
            prod     <= '0;
            k        <= '0;
            i        <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            n        <= n_nxt;
            acc      <= acc_nxt;
            prod     <= prod_nxt;
            k        <= k_nxt;
            i        <= i_nxt;
            result_q <= result_nxt;
            ovf_q    <= ovf_nxt;
            done_q   <= done_nxt;
            busy_q   <= busy_nxt;
        end
    end

    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_fact_engine.sv
// Self-checking bench for fact_engine: directed vector table, hand-written
// corner sequences and randomized jobs against an arithmetic factorial model.
module tb_fact_engine;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] exp_last;

    fact_engine_if bus ();

    fact_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  n;
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } vec_t;

`ifdef FACT_OVF_SAT_EN
    localparam logic [31:0] R13 = 32'hFFFF_FFFF;
    localparam logic [31:0] R20 = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] R13 = 32'h7328_CC00;
    localparam logic [31:0] R20 = 32'h82B4_0000;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input int n, output logic [31:0] r, output logic o,
                                  output int lat);
        longint unsigned a;
        a = 1;
        o = 1'b0;
        for (int f = 2; f <= n; f++) begin
            a = a * longint'(f);
            if (a >= 64'h1_0000_0000) o = 1'b1;
            a = a % 64'h1_0000_0000;
        end
        r = a[31:0];
`ifdef FACT_OVF_SAT_EN
        if (o) r = 32'hFFFF_FFFF;
`endif
        lat = (n <= 1) ? 2 : 7 * n - 5;
    endfunction

    // Called just after an edge; starts a job and follows it through done.
    task automatic run_job(input logic [4:0] n, input logic [31:0] exp_res,
                           input logic exp_ovf, input int exp_lat,
                           input bit noisy, input string tag);
        int   edges;
        logic hold_ok;
        hold_ok   = 1'b1;
        bus.start = 1'b1;
        bus.n_in  = n;
        @(posedge clk); #1;
        edges     = 1;
        bus.start = 1'b0;
        bus.n_in  = 5'($urandom);
        chk({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
        while (!bus.done && edges < 400) begin
            if (bus.result !== exp_last) hold_ok = 1'b0;
            bus.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.n_in  = 5'($urandom);
            @(posedge clk); #1;
            edges++;
        end
        bus.start = 1'b0;
        chk({tag, "_result_hold"}, 32'(hold_ok), 32'd1);
        chk({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        exp_last = exp_res;
        @(posedge clk); #1;
        chk({tag, "_done_cleared"}, 32'(bus.done), 32'd0);
        chk({tag, "_busy_cleared"}, 32'(bus.busy), 32'd0);
        chk({tag, "_result_kept"}, bus.result, exp_res);
        chk({tag, "_ovf_kept"}, 32'(bus.ovf), 32'(exp_ovf));
    endtask

    initial begin
        vec_t tbl [8];
        int   edges;
        logic saw_done;
        logic [31:0] mr;
        logic        mo;
        int          ml;
        int          rn;

        total = 0;
        bad   = 0;
        tbl[0] = '{5'd0,  32'd1,          1'b0, 2};
        tbl[1] = '{5'd1,  32'd1,          1'b0, 2};
        tbl[2] = '{5'd5,  32'd120,        1'b0, 30};
        tbl[3] = '{5'd12, 32'h1C8C_FC00,  1'b0, 79};
        tbl[4] = '{5'd13, R13,            1'b1, 86};
        tbl[5] = '{5'd2,  32'd2,          1'b0, 9};
        tbl[6] = '{5'd3,  32'd6,          1'b0, 16};
        tbl[7] = '{5'd20, R20,            1'b1, 135};

        // Reset with start held high: start must be ignored
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.n_in  = 5'd7;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", bus.result, 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_ovf", 32'(bus.ovf), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        exp_last  = 32'd0;
        @(posedge clk); #1;
        chk("idle_no_start_busy", 32'(bus.busy), 32'd0);

        for (int v = 0; v < 8; v++) begin
            run_job(tbl[v].n, tbl[v].res, tbl[v].ovf, tbl[v].lat, 1'b0,
                    $sformatf("vec%0d_n%0d", v, tbl[v].n));
        end

        // Second start at edge 10 while computing 6! must be ignored
        bus.start = 1'b1;
        bus.n_in  = 5'd6;
        @(posedge clk); #1;
        edges     = 1;
        bus.start = 1'b0;
        while (!bus.done && edges < 400) begin
            if (edges == 9) begin
                bus.start = 1'b1;
                bus.n_in  = 5'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        bus.start = 1'b0;
        chk("ignore_start_latency", 32'(edges), 32'd37);
        chk("ignore_start_result", bus.result, 32'd720);
        chk("ignore_start_ovf", 32'(bus.ovf), 32'd0);
        exp_last = 32'd720;
        @(posedge clk); #1;
        chk("ignore_start_idle", 32'(bus.busy), 32'd0);

        // Reset at edge 20 aborts an 8! computation with no done pulse
        saw_done  = 1'b0;
        bus.start = 1'b1;
        bus.n_in  = 5'd8;
        @(posedge clk); #1;
        edges     = 1;
        bus.start = 1'b0;
        while (edges < 19) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done) saw_done = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        if (bus.done) saw_done = 1'b1;
        rst = 1'b0;
        chk("abort_result", bus.result, 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        repeat (60) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        exp_last = 32'd0;
        run_job(5'd3, 32'd6, 1'b0, 16, 1'b0, "after_abort_n3");

        // Randomized jobs with start noise during computation
        for (int r = 0; r < 16; r++) begin
            rn = int'($urandom_range(0, 31));
            model(rn, mr, mo, ml);
            run_job(5'(rn), mr, mo, ml, 1'b1, $sformatf("rand%0d_n%0d", r, rn));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
